// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a native valid/ready memory port: one transaction in flight,
// round-robin or fixed priority, request registered toward memory, timeout abort with error pulse.
module mem_bus_arbiter #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        busy,
  output logic        grant,
  output logic        timeout_err
);

  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant;
  logic          r_last_grant;
  logic [CW-1:0] r_count;
  logic          r_instr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;

  logic          w_any;
  logic          w_winner;
  logic          w_norm;
  logic          w_to_hit;
  logic          w_done;
  logic [31:0]   w_rdata;

  assign w_any = m0_valid | m1_valid;

  always_comb begin
    if (m0_valid && m1_valid) begin
      w_winner = RR_EN ? ~r_last_grant : 1'b0;
    end else begin
      w_winner = m1_valid;
    end
  end

  // Completion is suppressed while reset is high so an aborted transaction never acks.
  assign w_norm   = (r_state == ST_BUSY) && s_mem_ready && !reset;
  assign w_to_hit = (TIMEOUT != 0) && (r_state == ST_BUSY) && (r_count == TO_LAST)
                    && !s_mem_ready && !reset;
  assign w_done   = w_norm | w_to_hit;
  assign w_rdata  = w_to_hit ? ERR_DATA : s_mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any)  w_next = ST_BUSY;
      ST_BUSY: if (w_done) w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_mem_valid = (r_state == ST_BUSY);
    busy        = (r_state == ST_BUSY);
    m0_ready    = w_done && (r_grant == 1'b0);
    m1_ready    = w_done && (r_grant == 1'b1);
    m0_rdata    = m0_ready ? w_rdata : '0;
    m1_rdata    = m1_ready ? w_rdata : '0;
    timeout_err = w_to_hit;
    grant       = r_grant;
    s_mem_instr = r_instr;
    s_mem_addr  = r_addr;
    s_mem_wdata = r_wdata;
    s_mem_wstrb = r_wstrb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_count      <= '0;
      r_instr      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        r_grant <= w_winner;
        r_count <= '0;
        r_instr <= w_winner ? m1_instr : m0_instr;
        r_addr  <= w_winner ? m1_addr  : m0_addr;
        r_wdata <= w_winner ? m1_wdata : m0_wdata;
        r_wstrb <= w_winner ? m1_wstrb : m0_wstrb;
      end
    end else begin
      if (w_done) begin
        r_last_grant <= r_grant;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 round-robin, instance 1 fixed priority, both TIMEOUT=8.
// A transaction-level model predicts every output each cycle; directed scenarios add explicit checks.
module tb_mem_bus_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       m0_valid, m0_instr, m0_ready, m1_valid, m1_instr, m1_ready;
  logic [1:0][31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [1:0][3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [1:0]       s_valid, s_instr, s_ready, busy, grant, terr, mem_en;
  logic [1:0][31:0] s_addr, s_wdata, s_rdata;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign s_ready[g] = s_valid[g] & mem_en[g];
    mem_bus_arbiter #(.RR_EN(g == 0), .TIMEOUT(TO), .ERR_DATA(ERR)) u_dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid[g]), .m0_instr(m0_instr[g]), .m0_addr(m0_addr[g]),
      .m0_wdata(m0_wdata[g]), .m0_wstrb(m0_wstrb[g]), .m0_ready(m0_ready[g]),
      .m0_rdata(m0_rdata[g]),
      .m1_valid(m1_valid[g]), .m1_instr(m1_instr[g]), .m1_addr(m1_addr[g]),
      .m1_wdata(m1_wdata[g]), .m1_wstrb(m1_wstrb[g]), .m1_ready(m1_ready[g]),
      .m1_rdata(m1_rdata[g]),
      .s_mem_valid(s_valid[g]), .s_mem_instr(s_instr[g]), .s_mem_addr(s_addr[g]),
      .s_mem_wdata(s_wdata[g]), .s_mem_wstrb(s_wstrb[g]), .s_mem_ready(s_ready[g]),
      .s_mem_rdata(s_rdata[g]),
      .busy(busy[g]), .grant(grant[g]), .timeout_err(terr[g])
    );
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          rst_drv;
  int unsigned start_pct [2];
  int unsigned mem_pct;
  bit          rd_force;
  logic [31:0] rd_val;

  // Requester-side transactions: pending until the model says they completed
  bit          pend     [2][2];
  bit          tx_instr [2][2];
  logic [31:0] tx_addr  [2][2];
  logic [31:0] tx_wdata [2][2];
  logic [3:0]  tx_wstrb [2][2];

  // Model: transaction in flight, its age in BUSY cycles, previous winner
  bit          mb_busy [2], mb_grant [2], mb_last [2], mb_instr [2];
  int unsigned mb_age [2];
  logic [31:0] mb_addr [2], mb_wdata [2];
  logic [3:0]  mb_wstrb [2];

  bit prev_busy [2];
  bit glog0 [$];
  bit glog1 [$];

  task automatic check(input string tag, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", tag, g, act, exp);
    end
  endtask

  task automatic new_txn(input int g, input int r);
    pend[g][r]     = 1'b1;
    tx_addr[g][r]  = $urandom;
    tx_wdata[g][r] = $urandom;
    tx_wstrb[g][r] = 4'($urandom_range(15));
    tx_instr[g][r] = 1'($urandom_range(1));
  endtask

  task automatic set_ports();
    for (int g = 0; g < 2; g++) begin
      m0_valid[g] = pend[g][0];     m1_valid[g] = pend[g][1];
      m0_instr[g] = tx_instr[g][0]; m1_instr[g] = tx_instr[g][1];
      m0_addr[g]  = tx_addr[g][0];  m1_addr[g]  = tx_addr[g][1];
      m0_wdata[g] = tx_wdata[g][0]; m1_wdata[g] = tx_wdata[g][1];
      m0_wstrb[g] = tx_wstrb[g][0]; m1_wstrb[g] = tx_wstrb[g][1];
    end
  endtask

  task automatic drive();
    reset = rst_drv;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++)
        if (!rst_drv && !pend[g][r] && $urandom_range(99) < start_pct[r]) new_txn(g, r);
      mem_en[g]  = ($urandom_range(99) < mem_pct);
      s_rdata[g] = rd_force ? rd_val : $urandom;
    end
    set_ports();
  endtask

  task automatic check_and_model();
    bit          nrm, toh, fin, w;
    logic [31:0] erd;
    for (int g = 0; g < 2; g++) begin
      nrm = !reset && mb_busy[g] && mem_en[g];
      toh = !reset && mb_busy[g] && !mem_en[g] && (mb_age[g] == TO - 1);
      fin = nrm || toh;
      erd = toh ? ERR : s_rdata[g];
      check("s_mem_valid", g, s_valid[g], mb_busy[g]);
      check("busy",        g, busy[g],    mb_busy[g]);
      check("grant",       g, grant[g],   mb_grant[g]);
      check("s_mem_instr", g, s_instr[g], mb_instr[g]);
      check("s_mem_addr",  g, s_addr[g],  mb_addr[g]);
      check("s_mem_wdata", g, s_wdata[g], mb_wdata[g]);
      check("s_mem_wstrb", g, s_wstrb[g], mb_wstrb[g]);
      check("m0_ready",    g, m0_ready[g], fin && !mb_grant[g]);
      check("m0_rdata",    g, m0_rdata[g], (fin && !mb_grant[g]) ? erd : 32'h0);
      check("m1_ready",    g, m1_ready[g], fin && mb_grant[g]);
      check("m1_rdata",    g, m1_rdata[g], (fin && mb_grant[g]) ? erd : 32'h0);
      check("timeout_err", g, terr[g], toh);

      if (busy[g] === 1'b1 && !prev_busy[g]) begin
        if (g == 0) glog0.push_back(grant[g]);
        else        glog1.push_back(grant[g]);
      end
      prev_busy[g] = (busy[g] === 1'b1);

      if (reset) begin
        mb_busy[g] = 0; mb_grant[g] = 0; mb_last[g] = 1; mb_age[g] = 0;
        mb_instr[g] = 0; mb_addr[g] = '0; mb_wdata[g] = '0; mb_wstrb[g] = '0;
      end else if (mb_busy[g]) begin
        if (fin) begin
          mb_busy[g] = 0;
          mb_last[g] = mb_grant[g];
          pend[g][mb_grant[g]] = 0;
        end else begin
          mb_age[g]++;
        end
      end else if (pend[g][0] || pend[g][1]) begin
        if (pend[g][0] && pend[g][1]) w = (g == 0) ? !mb_last[g] : 1'b0;
        else                          w = pend[g][1];
        mb_busy[g] = 1; mb_age[g] = 0; mb_grant[g] = w;
        mb_instr[g] = tx_instr[g][w]; mb_addr[g] = tx_addr[g][w];
        mb_wdata[g] = tx_wdata[g][w]; mb_wstrb[g] = tx_wstrb[g][w];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_and_model();
  endtask

  task automatic do_reset();
    rst_drv = 1;
    for (int g = 0; g < 2; g++) begin pend[g][0] = 0; pend[g][1] = 0; end
    repeat (2) cycle();
    rst_drv = 0;
  endtask

  int unsigned nb [2];
  int unsigned hit_at [2];
  logic [31:0] hrd [2];
  logic        hrdy [2];

  initial begin
    reset = 1'b1; rst_drv = 1; mem_en = '0; s_rdata = '0;
    start_pct = '{0, 0}; mem_pct = 0; rd_force = 0; rd_val = '0;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++) begin
        pend[g][r] = 0; tx_instr[g][r] = 0; tx_addr[g][r] = '0;
        tx_wdata[g][r] = '0; tx_wstrb[g][r] = '0;
      end
      mb_busy[g] = 0; mb_grant[g] = 0; mb_last[g] = 1; mb_age[g] = 0; mb_instr[g] = 0;
      mb_addr[g] = '0; mb_wdata[g] = '0; mb_wstrb[g] = '0; prev_busy[g] = 0;
    end
    set_ports();

    // Reset held 3 cycles, no requests
    repeat (3) cycle();
    for (int g = 0; g < 2; g++) begin
      check("rst_s_valid", g, s_valid[g], 0);
      check("rst_busy",    g, busy[g], 0);
      check("rst_grant",   g, grant[g], 0);
      check("rst_m0_rdy",  g, m0_ready[g], 0);
      check("rst_m1_rdy",  g, m1_ready[g], 0);
    end
    rst_drv = 0;

    // Single zero-wait read from m0
    mem_pct = 100; rd_force = 1; rd_val = 32'h1234_5678;
    for (int g = 0; g < 2; g++) begin
      pend[g][0] = 1; tx_addr[g][0] = 32'h100; tx_wstrb[g][0] = 4'h0;
      tx_instr[g][0] = 0; tx_wdata[g][0] = $urandom;
    end
    repeat (2) cycle();
    for (int g = 0; g < 2; g++) begin
      check("rd_ready", g, m0_ready[g], 1);
      check("rd_data",  g, m0_rdata[g], 32'h1234_5678);
      check("rd_addr",  g, s_addr[g], 32'h100);
    end
    rd_force = 0;
    cycle();

    // Continuous contention: RR gives 0,1,0,1; fixed gives 0,0,0,0
    do_reset();
    glog0.delete(); glog1.delete();
    start_pct = '{100, 100}; mem_pct = 100;
    for (int c = 0; c < 40 && (glog0.size() < 4 || glog1.size() < 4); c++) cycle();
    check("rr_grants", 0, glog0.size(), 4);
    check("fx_grants", 1, glog1.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog0.size()) check("rr_order", 0, glog0[i], i % 2);
      if (i < glog1.size()) check("fx_order", 1, glog1[i], 0);
    end
    glog1.delete();
    start_pct = '{0, 0};
    repeat (10) cycle();
    check("fx_m1_late", 1, (glog1.size() > 0) ? glog1[glog1.size() - 1] : 1'b0, 1);

    // Timeout on an m1 write with memory never ready
    do_reset();
    mem_pct = 0;
    for (int g = 0; g < 2; g++) begin
      pend[g][1] = 1; tx_addr[g][1] = 32'h200; tx_wstrb[g][1] = 4'hF;
      tx_instr[g][1] = 0; tx_wdata[g][1] = $urandom;
      nb[g] = 0; hit_at[g] = 0; hrd[g] = '0; hrdy[g] = 0;
    end
    for (int c = 0; c < 20; c++) begin
      cycle();
      for (int g = 0; g < 2; g++) begin
        if (busy[g] === 1'b1) nb[g]++;
        if (terr[g] === 1'b1 && hit_at[g] == 0) begin
          hit_at[g] = nb[g]; hrd[g] = m1_rdata[g]; hrdy[g] = m1_ready[g];
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      check("to_cycle", g, hit_at[g], 8);
      check("to_rdata", g, hrd[g], ERR);
      check("to_ready", g, hrdy[g], 1);
    end

    // Reset in the 2nd BUSY cycle, then both requesters valid
    do_reset();
    mem_pct = 0;
    for (int g = 0; g < 2; g++) new_txn(g, 0);
    repeat (2) cycle();
    rst_drv = 1;
    cycle();
    for (int g = 0; g < 2; g++) new_txn(g, 1);
    rst_drv = 0;
    cycle();
    for (int g = 0; g < 2; g++) begin
      check("rm_s_valid", g, s_valid[g], 0);
      check("rm_m0_rdy",  g, m0_ready[g], 0);
    end
    cycle();
    for (int g = 0; g < 2; g++) begin
      check("rm_grant", g, grant[g], 0);
      check("rm_busy",  g, busy[g], 1);
    end
    mem_pct = 100;
    repeat (6) cycle();

    // Randomized traffic against the model
    do_reset();
    start_pct = '{60, 60}; mem_pct = 70;
    repeat (400) cycle();
    start_pct = '{95, 95}; mem_pct = 40;
    repeat (400) cycle();
    start_pct = '{30, 80}; mem_pct = 10;
    repeat (400) cycle();
    start_pct = '{0, 0}; mem_pct = 100;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
